aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl_pkg.sv | 25 ++
 rtl/aes_key_sched_ctrl_rkbuf.sv | 65 ++++++
 rtl/aes_key_sched_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared definitions for the AES-128 key schedule controller.
package aes_key_sched_ctrl_pkg;

    localparam int NUM_ROUNDS  = 10;
    localparam int NUM_RKEYS   = NUM_ROUNDS + 1;
    localparam int ROUND_KEY_W = 128;
    localparam int SCHED_W     = NUM_RKEYS * ROUND_KEY_W;
    localparam int RK_IDX_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_STORE  = 2'd2,
        ST_READY  = 2'd3
    } ks_state_e;

    // Round 0 sits in the most significant 128 bits of the schedule.
    function automatic logic [ROUND_KEY_W-1:0] sched_word(
        input logic [SCHED_W-1:0] sched,
        input int                 idx
    );
        return sched[SCHED_W-1-ROUND_KEY_W*idx -: ROUND_KEY_W];
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_rkbuf.sv
// Round-key buffer: 11 x 128-bit storage with a one-cycle registered read port.
module aes_key_sched_ctrl_rkbuf
    import aes_key_sched_ctrl_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_en,
    input  logic [SCHED_W-1:0]     i_sched,
    input  logic                   i_rd_en,
    input  logic [RK_IDX_W-1:0]    i_rd_idx,
    output logic                   o_rd_valid,
    output logic [ROUND_KEY_W-1:0] o_rd_data,
    output logic                   o_rd_err
);

    logic [ROUND_KEY_W-1:0] r_buf [NUM_RKEYS];
    logic                   r_rd_valid;
    logic [ROUND_KEY_W-1:0] r_rd_data;
    logic                   r_rd_err;
    logic [ROUND_KEY_W-1:0] w_rd_word;
    logic                   w_idx_bad;

    // Read mux; indices past the last round fall through to zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_RKEYS; i++) begin
            if (i_rd_idx == RK_IDX_W'(i)) begin
                w_rd_word = r_buf[i];
            end
        end
    end

    assign w_idx_bad = (i_rd_idx > RK_IDX_W'(NUM_ROUNDS));

    // Whole schedule captured in one cycle when the controller asks for it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_RKEYS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int i = 0; i < NUM_RKEYS; i++) begin
                r_buf[i] <= sched_word(i_sched, i);
            end
        end
    end

    // One response per request cycle, data and error aligned with valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            r_rd_data  <= i_rd_en ? w_rd_word : '0;
            r_rd_err   <= i_rd_en & w_idx_bad;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_rd_err   = r_rd_err;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: accepts a cipher key, drives an external
// key_expansion block, stores the resulting schedule and serves round keys.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no schedule held, waiting for a key
// ST_EXPAND | key_expansion running, timeout counter advancing
// ST_STORE  | capture expanded schedule into the round-key buffer
// ST_READY  | schedule valid, round-key reads served, reload allowed if idle
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ROUND_KEY_W-1:0] i_key_in,
    input  logic                   i_key_valid,
    output logic                   o_key_ready,
    output logic                   o_kx_enable,
    output logic [ROUND_KEY_W-1:0] o_kx_key,
    input  logic [SCHED_W-1:0]     i_kx_out,
    input  logic                   i_kx_done,
    input  logic                   i_cipher_busy,
    input  logic                   i_rk_req,
    input  logic [RK_IDX_W-1:0]    i_rk_idx,
    output logic                   o_rk_valid,
    output logic [ROUND_KEY_W-1:0] o_rk_data,
    output logic                   o_rk_err,
    output logic                   o_keys_ready,
    output logic                   o_err_timeout
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ks_state_e              r_state;
    ks_state_e              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [ROUND_KEY_W-1:0] r_kx_key;
    logic                   r_err_timeout;
    logic                   w_key_ready;
    logic                   w_key_xfer;
    logic                   w_timeout_hit;
    logic                   w_store;
    logic                   w_rd_en;

    // Next-state and combinational handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_key_ready   = 1'b0;
        w_timeout_hit = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_key_ready = 1'b1;
                if (i_key_valid) begin
                    w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                // Completion takes priority over a coincident timeout.
                if (i_kx_done) begin
                    w_state_nxt = ST_STORE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_STORE: begin
                w_state_nxt = ST_READY;
            end
            ST_READY: begin
                w_key_ready = ~i_cipher_busy;
                if (i_key_valid && !i_cipher_busy) begin
                    w_state_nxt = ST_EXPAND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_key_xfer = i_key_valid & w_key_ready;
    assign w_store    = (r_state == ST_STORE);
    assign w_rd_en    = i_rk_req & (r_state == ST_READY);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key latch and expansion timeout counter, both restarted by a key transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kx_key <= '0;
            r_cnt    <= '0;
        end else if (w_key_xfer) begin
            r_kx_key <= i_key_in;
            r_cnt    <= '0;
        end else if (r_state == ST_EXPAND) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Timeout flag is a single registered pulse on the cycle after expiry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_timeout_hit;
        end
    end

    aes_key_sched_ctrl_rkbuf u_rkbuf (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (w_store),
        .i_sched    (i_kx_out),
        .i_rd_en    (w_rd_en),
        .i_rd_idx   (i_rk_idx),
        .o_rd_valid (o_rk_valid),
        .o_rd_data  (o_rk_data),
        .o_rd_err   (o_rk_err)
    );

    assign o_key_ready   = w_key_ready;
    assign o_kx_enable   = (r_state == ST_EXPAND);
    assign o_kx_key      = r_kx_key;
    assign o_keys_ready  = (r_state == ST_READY);
    assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl with a behavioural key_expansion stand-in and
// a queue-based scoreboard for round-key responses.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [127:0]    key_in = '0;
    logic            key_valid = 1'b0;
    logic            key_ready;
    logic            kx_enable;
    logic [127:0]    kx_key;
    logic [1407:0]   kx_out;
    logic            kx_done;
    logic            cipher_busy = 1'b0;
    logic            rk_req = 1'b0;
    logic [3:0]      rk_idx = '0;
    logic            rk_valid;
    logic [127:0]    rk_data;
    logic            rk_err;
    logic            keys_ready;
    logic            err_timeout;

    logic            kx_hang = 1'b0;
    logic [2:0]      kx_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    typedef struct {
        logic [127:0] data;
        logic         err;
        int           due;
    } exp_t;
    exp_t exp_q[$];

    aes_key_sched_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_key_in      (key_in),
        .i_key_valid   (key_valid),
        .o_key_ready   (key_ready),
        .o_kx_enable   (kx_enable),
        .o_kx_key      (kx_key),
        .i_kx_out      (kx_out),
        .i_kx_done     (kx_done),
        .i_cipher_busy (cipher_busy),
        .i_rk_req      (rk_req),
        .i_rk_idx      (rk_idx),
        .o_rk_valid    (rk_valid),
        .o_rk_data     (rk_data),
        .o_rk_err      (rk_err),
        .o_keys_ready  (keys_ready),
        .o_err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ---------------- reference AES-128 key expansion ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = '0;
        if (x != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
            end
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] s;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = '0;
        for (int i = 0; i < 44; i++) s[1407-32*i -: 32] = w[i];
        return s;
    endfunction

    function automatic logic [127:0] rk_of(input logic [1407:0] s, input int i);
        return s[1407-128*i -: 128];
    endfunction

    // Stand-in key_expansion: done four cycles into enable, unless hung.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         kx_cnt <= '0;
        else if (kx_enable) kx_cnt <= kx_cnt + 3'd1;
        else                kx_cnt <= '0;
    end

    assign kx_done = kx_enable & (kx_cnt == 3'd3) & ~kx_hang;

    always_comb kx_out = key_expand(kx_key);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every rk_valid pops the oldest expectation.
    always @(negedge clk) begin
        if (rk_valid) begin
            if (exp_q.size() == 0) begin
                check("rk_unexpected_valid", 128'(rk_valid), 128'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rk_latency", 128'(cyc), 128'(e.due));
                check("rk_data", rk_data, e.data);
                check("rk_err", 128'(rk_err), 128'(e.err));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rk_missing_valid", 128'(rk_valid), 128'd1);
        end
    end

    // Drive one request cycle and record the expected response.
    task automatic issue_rd(input logic [3:0] idx, input logic [127:0] d, input logic e);
        exp_t x;
        rk_req = 1'b1;
        rk_idx = idx;
        x.data = d; x.err = e; x.due = cyc + 1;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic wait_keys_ready(input string name);
        for (int i = 0; i < 20 && !keys_ready; i++) @(negedge clk);
        check(name, 128'(keys_ready), 128'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_ready"},   128'(key_ready),   128'd1);
        check({tag, "_kx_enable"},   128'(kx_enable),   128'd0);
        check({tag, "_kx_key"},      kx_key,            128'd0);
        check({tag, "_rk_valid"},    128'(rk_valid),    128'd0);
        check({tag, "_rk_data"},     rk_data,           128'd0);
        check({tag, "_rk_err"},      128'(rk_err),      128'd0);
        check({tag, "_keys_ready"},  128'(keys_ready),  128'd0);
        check({tag, "_err_timeout"}, 128'(err_timeout), 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1407:0] ref1;
        int            xfer_cyc;
        int            seen;
        logic          any_bad;

        ref1 = key_expand(K1);

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Requests in IDLE are ignored.
        rk_req = 1'b1; rk_idx = 4'd0;
        @(negedge clk);
        rk_req = 1'b0;
        check("idle_rk_ignored", 128'(rk_valid), 128'd0);

        // First key load with the reference vector.
        key_valid = 1'b1; key_in = K1;
        @(negedge clk);
        key_valid = 1'b0;
        check("load1_kx_enable", 128'(kx_enable), 128'd1);
        check("load1_kx_key",    kx_key,          K1);
        check("load1_key_ready", 128'(key_ready), 128'd0);
        wait_keys_ready("load1_keys_ready");

        // Back-to-back reads, including out-of-range indices.
        issue_rd(4'd0,  K1,     1'b0);
        issue_rd(4'd1,  K1_R1,  1'b0);
        issue_rd(4'd10, K1_R10, 1'b0);
        for (int i = 2; i < 10; i++) issue_rd(4'(i), rk_of(ref1, i), 1'b0);
        issue_rd(4'd12, '0, 1'b1);
        issue_rd(4'd15, '0, 1'b1);
        issue_rd(4'd11, '0, 1'b1);
        rk_req = 1'b0;
        @(negedge clk);

        // Reload blocked while the cipher is busy.
        cipher_busy = 1'b1; key_valid = 1'b1; key_in = K2;
        #1 check("busy_key_ready", 128'(key_ready), 128'd0);
        @(negedge clk);
        check("busy_no_expand",  128'(kx_enable),  128'd0);
        check("busy_keys_ready", 128'(keys_ready), 128'd1);
        check("busy_kx_key",     kx_key,           K1);
        cipher_busy = 1'b0;
        #1 check("unbusy_key_ready", 128'(key_ready), 128'd1);
        @(negedge clk);
        key_valid = 1'b0;
        check("unbusy_kx_enable", 128'(kx_enable), 128'd1);
        check("unbusy_kx_key",    kx_key,          K2);
        wait_keys_ready("load2_keys_ready");
        issue_rd(4'd0,  K2,     1'b0);
        issue_rd(4'd10, K2_R10, 1'b0);
        rk_req = 1'b0;
        @(negedge clk);

        // Reload coincident with a read: old schedule answers the read.
        key_valid = 1'b1; key_in = K1;
        issue_rd(4'd10, K2_R10, 1'b0);
        key_valid = 1'b0; rk_req = 1'b0;
        check("reload_keys_ready_low", 128'(keys_ready), 128'd0);
        check("reload_kx_enable",      128'(kx_enable),  128'd1);
        wait_keys_ready("reload_keys_ready");
        issue_rd(4'd10, K1_R10, 1'b0);
        issue_rd(4'd0,  K1,     1'b0);
        rk_req = 1'b0;
        @(negedge clk);

        // Expansion that never completes.
        kx_hang = 1'b1;
        key_valid = 1'b1; key_in = K2;
        xfer_cyc = cyc + 1;
        @(negedge clk);
        key_valid = 1'b0;
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            if (err_timeout) begin
                seen = cyc;
                break;
            end
            @(negedge clk);
        end
        check("timeout_latency",    128'(seen - xfer_cyc), 128'd8);
        check("timeout_key_ready",  128'(key_ready),  128'd1);
        check("timeout_keys_ready", 128'(keys_ready), 128'd0);
        @(negedge clk);
        check("timeout_single_pulse", 128'(err_timeout), 128'd0);
        check("timeout_kx_enable",    128'(kx_enable),   128'd0);
        kx_hang = 1'b0;

        // Reset in the middle of an expansion.
        key_valid = 1'b1; key_in = K1;
        @(negedge clk);
        key_valid = 1'b0;
        check("pre_reset_kx_enable", 128'(kx_enable), 128'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        any_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (err_timeout || keys_ready || kx_enable) any_bad = 1'b1;
        end
        check("post_reset_quiet", 128'(any_bad), 128'd0);
        key_valid = 1'b1; key_in = K1;
        @(negedge clk);
        key_valid = 1'b0;
        check("post_reset_kx_enable", 128'(kx_enable), 128'd1);
        wait_keys_ready("post_reset_keys_ready");
        issue_rd(4'd1, K1_R1, 1'b0);
        rk_req = 1'b0;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
